key_move_ctrl: RTL
==================

// Module: key_move_ctrl
// PURPOSE
//  Per-frame player movement controller between keyboard and objectbank/VGA.
//  Consumes the decoded keys_pressed vector and a once-per-frame tick.
//  Produces a clamped (hpos, vpos) cursor position with first-press stepping
//  and auto-repeat.
//  Emits one-cycle shift_left/shift_right pulses that advance the objectbank.
//  Replaces the free-running per-clock position logic at top level.
// PARAMETERS
//  HPOS_INIT     200  hpos value after reset and on recentre
//  VPOS_INIT     200  vpos value after reset and on recentre
//  HPOS_MIN      0    lowest legal hpos (saturate, never wrap)
//  HPOS_MAX      639  highest legal hpos
//  VPOS_MIN      0    lowest legal vpos
//  VPOS_MAX      479  highest legal vpos
//  STEP          4    pixels moved per step (unsigned, 1..31)
//  REPEAT_DELAY  15   frames a key is held before auto-repeat starts (>=1)
//  REPEAT_RATE   3    frames between auto-repeat steps (>=1)
// PORTS
//  clk           in   1   100 MHz system clock
//  rst           in   1   asynchronous reset, active-high
//  keys_pressed  in   5   [0]=up [1]=left [2]=down [3]=right [4]=centre (levels)
//  frame_tick    in   1   single-cycle pulse, once per VGA frame
//  game_over     in   1   level; while high, movement is frozen
//  hpos          out  10  current horizontal position
//  vpos          out  10  current vertical position
//  shift_left    out  1   1-cycle pulse: a left step changed hpos
//  shift_right   out  1   1-cycle pulse: a right step changed hpos
//  move_valid    out  1   1-cycle pulse: hpos or vpos changed this cycle
// BEHAVIOUR
//  - Reset (async, rst=1):
//    - hpos=HPOS_INIT, vpos=VPOS_INIT; all pulses 0; FSM=IDLE; counter=0.
//  - Sampling:
//    - keys_pressed is evaluated only on clk edges where frame_tick=1.
//    - Every other cycle holds all state; pulses return to 0.
//  - Direction select on a tick:
//    - Priority centre > up > down > left > right.
//    - Opposing keys pressed together resolve by this priority.
//    - dir=NONE when no key is pressed.
//  - Centre: on a tick with key[4]=1, load HPOS_INIT/VPOS_INIT.
//    - FSM goes to IDLE.
//    - move_valid pulses only if a value changed.
//  - FSM, with states IDLE, HOLD and REPEAT; cur_dir is registered:
//    - IDLE: tick, dir!=NONE -> step(dir), cur_dir=dir, cnt=REPEAT_DELAY-1, ->HOLD.
//    - HOLD: tick, dir=NONE -> IDLE.
//      - dir!=cur_dir -> step(dir), cur_dir=dir, cnt=REPEAT_DELAY-1, stay HOLD.
//      - cnt==0 -> step(cur_dir), cnt=REPEAT_RATE-1, ->REPEAT; else cnt--.
//    - REPEAT: tick, dir=NONE -> IDLE; dir change handled as in HOLD.
//      - cnt==0 -> step, cnt=REPEAT_RATE-1; else cnt--.
//  - Step arithmetic:
//    - Computed in 11 bits; result saturates to [MIN,MAX].
//    - Example: hpos=2, STEP=4, left -> 0.
//    - Example: vpos=478, down -> 479.
//    - A step at a bound leaves the position unchanged.
//      - No shift_* or move_valid pulse is emitted for it.
//      - The FSM still advances.
//  - Latency: new hpos/vpos and pulses are visible the cycle after the tick edge.
//    - Outputs are registered.
//    - Pulses last exactly one clk.
//  - game_over=1 on a tick:
//    - FSM forced to IDLE; no step, no centre.
//    - Positions hold; pulses stay 0.
//    - Movement resumes on the first tick after game_over falls.
//    - The key is treated as a new press.
//  - Reset asserted mid-HOLD/REPEAT aborts immediately to reset values.
//    - No pulse is emitted on the release edge.
// TESTING
//  - Reset release, no keys, 10 ticks:
//    - hpos=200, vpos=200 throughout; no pulses.
//  - Hold right (key[3]) for 20 ticks, STEP=4:
//    - Steps on ticks 1, 16, 19.
//    - hpos=212 after tick 20; 3 shift_right pulses, each 1 cycle.
//  - Hold left from hpos=6:
//    - Tick 1 gives 2; the next step gives 0.
//    - Later steps: no shift_left pulse, hpos stays 0.
//  - Up+down held together at vpos=200:
//    - Tick 1 gives vpos=196 (up wins).
//    - Release both on the next tick: FSM returns to IDLE.
//  - game_over=1 while holding right:
//    - hpos frozen across 10 ticks.
//    - Drop game_over: the next tick steps +4 immediately.
//  - Assert rst for 3 cycles mid-REPEAT at hpos=300:
//    - hpos=200 asynchronously; no pulses around the reset edges.

Source files
------------

// File: rtl/key_move_ctrl.sv
// key_move_ctrl
//   Per-frame player movement controller. Samples the decoded key levels once
//   per VGA frame, steps a clamped (hpos, vpos) cursor on a first press and
//   again under auto-repeat while the key is held, and pulses shift_left /
//   shift_right to advance the object bank when a horizontal step lands.
//
// Ports
//   clk          in   system clock
//   rst          in   asynchronous reset, active-high
//   keys_pressed in   [0]=up [1]=left [2]=down [3]=right [4]=centre (levels)
//   frame_tick   in   single-cycle pulse, once per frame; keys sampled only here
//   game_over    in   level; freezes movement and forces the FSM idle
//   hpos, vpos   out  current cursor position (registered)
//   shift_left   out  1-cycle pulse: a left step changed hpos
//   shift_right  out  1-cycle pulse: a right step changed hpos
//   move_valid   out  1-cycle pulse: hpos or vpos changed
module key_move_ctrl #(
    parameter int unsigned HPOS_INIT    = 200,
    parameter int unsigned VPOS_INIT    = 200,
    parameter int unsigned HPOS_MIN     = 0,
    parameter int unsigned HPOS_MAX     = 639,
    parameter int unsigned VPOS_MIN     = 0,
    parameter int unsigned VPOS_MAX     = 479,
    parameter int unsigned STEP         = 4,
    parameter int unsigned REPEAT_DELAY = 15,
    parameter int unsigned REPEAT_RATE  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] keys_pressed,
    input  logic       frame_tick,
    input  logic       game_over,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       shift_left,
    output logic       shift_right,
    output logic       move_valid
);

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT} state_t;
    typedef enum logic [2:0] {D_NONE, D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

    localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [9:0]  HINIT   = 10'(HPOS_INIT);
    localparam logic [9:0]  VINIT   = 10'(VPOS_INIT);
    localparam logic [10:0] STEP_11 = 11'(STEP);
    localparam logic [10:0] HMIN_11 = 11'(HPOS_MIN);
    localparam logic [10:0] HMAX_11 = 11'(HPOS_MAX);
    localparam logic [10:0] VMIN_11 = 11'(VPOS_MIN);
    localparam logic [10:0] VMAX_11 = 11'(VPOS_MAX);

    // Decrement by STEP in 11 bits so the borrow is visible; clamp at lo.
    function automatic logic [9:0] step_dec(input logic [9:0] pos, input logic [10:0] lo);
        logic [10:0] p;
        logic [10:0] r;
        p = {1'b0, pos};
        r = p - STEP_11;
        if (p < lo + STEP_11) return lo[9:0];
        return r[9:0];
    endfunction

    // Increment by STEP in 11 bits so overflow past 1023 cannot wrap; clamp at hi.
    function automatic logic [9:0] step_inc(input logic [9:0] pos, input logic [10:0] hi);
        logic [10:0] s;
        s = {1'b0, pos} + STEP_11;
        if (s > hi) return hi[9:0];
        return s[9:0];
    endfunction

    state_t           state_q, state_d;
    dir_t             cur_dir_q, cur_dir_d;
    dir_t             dir, step_dir;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       hpos_q, hpos_d, vpos_q, vpos_d;
    logic             sl_q, sl_d, sr_q, sr_d, mv_q, mv_d;
    logic             do_step;

    // Fixed priority: up > down > left > right (centre is handled separately).
    always_comb begin
        dir = D_NONE;
        if (keys_pressed[0])      dir = D_UP;
        else if (keys_pressed[2]) dir = D_DOWN;
        else if (keys_pressed[1]) dir = D_LEFT;
        else if (keys_pressed[3]) dir = D_RIGHT;
    end

    always_comb begin
        state_d   = state_q;
        cur_dir_d = cur_dir_q;
        cnt_d     = cnt_q;
        hpos_d    = hpos_q;
        vpos_d    = vpos_q;
        do_step   = 1'b0;
        step_dir  = D_NONE;

        if (frame_tick) begin
            if (game_over) begin
                // Dropping to IDLE makes the held key count as a new press later.
                state_d = S_IDLE;
            end else if (keys_pressed[4]) begin
                hpos_d  = HINIT;
                vpos_d  = VINIT;
                state_d = S_IDLE;
            end else if (dir == D_NONE) begin
                state_d = S_IDLE;
            end else if (state_q == S_IDLE || dir != cur_dir_q) begin
                do_step   = 1'b1;
                step_dir  = dir;
                cur_dir_d = dir;
                cnt_d     = CNT_W'(REPEAT_DELAY - 1);
                state_d   = S_HOLD;
            end else if (cnt_q == '0) begin
                do_step  = 1'b1;
                step_dir = cur_dir_q;
                cnt_d    = CNT_W'(REPEAT_RATE - 1);
                state_d  = S_REPEAT;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        if (do_step) begin
            case (step_dir)
                D_UP:    vpos_d = step_dec(vpos_q, VMIN_11);
                D_DOWN:  vpos_d = step_inc(vpos_q, VMAX_11);
                D_LEFT:  hpos_d = step_dec(hpos_q, HMIN_11);
                D_RIGHT: hpos_d = step_inc(hpos_q, HMAX_11);
                default: ;
            endcase
        end

        // Pulses only when a position actually moved; a clamped step is silent.
        sl_d = (step_dir == D_LEFT)  && (hpos_d != hpos_q);
        sr_d = (step_dir == D_RIGHT) && (hpos_d != hpos_q);
        mv_d = (hpos_d != hpos_q) || (vpos_d != vpos_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cur_dir_q <= D_NONE;
            cnt_q     <= '0;
            hpos_q    <= HINIT;
            vpos_q    <= VINIT;
            sl_q      <= 1'b0;
            sr_q      <= 1'b0;
            mv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_dir_q <= cur_dir_d;
            cnt_q     <= cnt_d;
            hpos_q    <= hpos_d;
            vpos_q    <= vpos_d;
            sl_q      <= sl_d;
            sr_q      <= sr_d;
            mv_q      <= mv_d;
        end
    end

    assign hpos        = hpos_q;
    assign vpos        = vpos_q;
    assign shift_left  = sl_q;
    assign shift_right = sr_q;
    assign move_valid  = mv_q;

endmodule
